pipe_share_arbiter: RTL and testbench
=====================================

// Module: pipe_share_arbiter
// PURPOSE
// - Shares one fixed-latency pipelined datapath (a pipeline_registers-style stage chain) among NUM_REQ requesters.
// - Round-robin grant issues at most one operand per cycle into the datapath.
// - A matching tag delay line tracks valid+requester id and steers each result back to its owner after LATENCY cycles.
// - Sits between requester engines and a shared compute pipe; no backpressure on the result side.
// PARAMETERS
// - NUM_REQ  4   number of requesters, >=2
// - DW       16  operand width per requester
// - RW       16  result width from datapath
// - LATENCY  5   datapath stages, >=1 (elaboration error if 0)
// - IDW      $clog2(NUM_REQ)            requester id width (localparam)
// - CW       $clog2(LATENCY+1)          in-flight counter width (localparam)
// PORTS
// - clk            in   1           rising-edge clock
// - reset          in   1           async, active-high reset
// - issue_en       in   1           0 = hold off all grants (drain mode)
// - req            in   NUM_REQ     per-requester request, held until granted
// - req_data       in   NUM_REQ*DW  operands, requester k at [k*DW +: DW]
// - gnt            out  NUM_REQ     one-hot grant, combinational, same cycle as issue
// - pipe_in_valid  out  1           operand presented to datapath this cycle
// - pipe_in_data   out  DW          muxed operand of granted requester
// - pipe_out_data  in   RW          datapath output, valid LATENCY cycles after issue
// - rsp_valid      out  NUM_REQ     one-hot result strobe to owner
// - rsp_data       out  RW          = pipe_out_data (broadcast, qualify with rsp_valid)
// - in_flight      out  CW          operations issued but not yet retired
// - idle           out  1           in_flight==0 && tag line empty && no grant this cycle
// BEHAVIOUR
// - Reset values:
//   - rr pointer = 0
//   - tag valids = 0; tag ids = 0
//   - in_flight = 0
//   - rsp_valid = 0; gnt = 0 while reset is high
//   - idle = 1
// - Issue condition: issue = issue_en && |req. When issue is 0, gnt=0 and pipe_in_valid=0.
// - Winner selection:
//   - Winner is the first set req at or after rr pointer, wrapping modulo NUM_REQ.
//   - gnt[winner]=1; pipe_in_data = req_data[winner]; pipe_in_valid=1.
// - Pointer update: on each issue, rr pointer <= (winner+1) mod NUM_REQ, registered. Without issue the pointer holds.
// - Tag line:
//   - LATENCY-stage shift of {valid, id}; stage0 <= {issue, winner} every cycle.
//   - Advances unconditionally, mirroring the datapath, which has no enable.
// - Retire:
//   - rsp_valid[id_out] = valid_out (registered tag output, no extra logic delay).
//   - rsp_valid is asserted exactly LATENCY cycles after the grant cycle.
//   - rsp_data passes pipe_out_data combinationally.
// - in_flight counter:
//   - +1 on issue-only, -1 on retire-only, unchanged on both or neither.
//   - Never exceeds LATENCY; never wraps.
// - Back-to-back issue is allowed every cycle (throughput 1/cycle).
// - Fairness: continuously requesting sources are each granted within NUM_REQ cycles.
// - issue_en deassert mid-stream: in-flight ops still retire normally; idle rises once drained.
// - Requester dropping req without grant is legal; no state is kept per request.
// - Reset mid-operation:
//   - All in-flight tags are discarded immediately.
//   - No rsp_valid is produced for them, even though datapath contents may persist.
//   - in_flight returns to 0.
// STRUCTURE
// - Shared package pipe_share_pkg: default NUM_REQ/DW/RW/LATENCY constants, id width function, tag struct typedef {valid, id}.
// - Sub-module tag_delay_line: LATENCY-stage registered shift of (1+IDW) bits with async active-high clear.
// - Round-robin pick, counter and output decode stay in the top.
// TESTING
// - Single req[2] with issue_en=1 at cycle 0 (LATENCY=5):
//   - cycle 0: gnt=0100, pipe_in_data=req_data[2].
//   - cycle 5: rsp_valid=0100, in_flight=1 during cycles 1-5, 0 at cycle 6.
// - All four req held high for 8 cycles from reset:
//   - Grant order is 0,1,2,3,0,1,2,3.
//   - rsp_valid repeats the same order from cycle 5; in_flight saturates at 5.
// - req=1010 with pointer=2: gnt=1000 first, then 0010; pointer ends at 2.
// - issue_en=0 with req=1111 for 3 cycles then 1:
//   - gnt=0 and pipe_in_valid=0 during hold.
//   - Earlier in-flight ops retire on schedule; idle=1 when drained.
// - Reset pulse 2 cycles after three back-to-back issues: no rsp_valid ever asserts for them; in_flight=0, idle=1 next cycle.
// - Issue and retire in the same cycle (steady stream): in_flight stays constant at LATENCY.

Source files
------------

// File: rtl/pipe_share_pkg.sv
// Shared constants and types for the shared-pipe arbiter: default sizing,
// id width helper and the default-configuration tag layout.
package pipe_share_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DW      = 16;
    localparam int DEF_RW      = 16;
    localparam int DEF_LATENCY = 5;

    function automatic int id_width(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

    localparam int DEF_IDW = id_width(DEF_NUM_REQ);

    typedef struct packed {
        logic               valid;
        logic [DEF_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/pipe_share_arbiter_if.sv
// Requester and datapath bundle around the shared-pipe arbiter; the arbiter
// takes the slave side, the requesters plus compute pipe take the master side.
interface pipe_share_arbiter_if #(
    parameter int NUM_REQ = pipe_share_pkg::DEF_NUM_REQ,
    parameter int DW      = pipe_share_pkg::DEF_DW,
    parameter int RW      = pipe_share_pkg::DEF_RW,
    parameter int LATENCY = pipe_share_pkg::DEF_LATENCY
);
    localparam int CW = $clog2(LATENCY + 1);

    logic                  issue_en;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    gnt;
    logic                  pipe_in_valid;
    logic [DW-1:0]         pipe_in_data;
    logic [RW-1:0]         pipe_out_data;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [RW-1:0]         rsp_data;
    logic [CW-1:0]         in_flight;
    logic                  idle;

    modport master (
        output issue_en, req, req_data, pipe_out_data,
        input  gnt, pipe_in_valid, pipe_in_data, rsp_valid, rsp_data, in_flight, idle
    );

    modport slave (
        input  issue_en, req, req_data, pipe_out_data,
        output gnt, pipe_in_valid, pipe_in_data, rsp_valid, rsp_data, in_flight, idle
    );

endinterface

// File: rtl/pipe_share_arbiter_tag_delay_line.sv
// Fixed-depth shift register that carries {valid, id} alongside the datapath.
// The MSB of each entry is its valid flag; any_valid reports a non-empty line.
module tag_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             any_valid
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: every stage is cleared so tags in flight are dropped on reset.
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            // NOTE: non-blocking keeps each stage reading its neighbour's old value.
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

    always_comb begin
        // NOTE: defaulted before the loop so no latch is inferred.
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage[i][WIDTH-1];
    end

endmodule

// File: rtl/pipe_share_arbiter.sv
// Round-robin front end for a shared fixed-latency datapath; a tag line
// returns each result to the requester that issued it LATENCY cycles earlier.
module pipe_share_arbiter #(
    parameter int NUM_REQ = pipe_share_pkg::DEF_NUM_REQ,
    parameter int DW      = pipe_share_pkg::DEF_DW,
    parameter int RW      = pipe_share_pkg::DEF_RW,
    parameter int LATENCY = pipe_share_pkg::DEF_LATENCY
) (
    input logic                 clk,
    input logic                 reset,
    pipe_share_arbiter_if.slave bus
);
    import pipe_share_pkg::*;

    localparam int IDW = id_width(NUM_REQ);
    localparam int CW  = $clog2(LATENCY + 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("pipe_share_arbiter: LATENCY must be at least 1");
    end
    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("pipe_share_arbiter: NUM_REQ must be at least 2");
    end

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } req_tag_t;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic           found;
    logic           issue;
    logic           retire;
    logic [CW-1:0]  in_flight_q;
    req_tag_t       tag_in;
    req_tag_t       tag_out;
    logic           tag_busy;

    // Scan from the pointer upward, wrapping, and take the first request seen.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req[idx]) begin
                winner = IDW'(idx);
                found  = 1'b1;
            end
        end
    end

    assign issue             = bus.issue_en && (|bus.req) && !reset;
    assign bus.gnt           = issue ? (NUM_REQ'(1) << winner) : '0;
    assign bus.pipe_in_valid = issue;
    assign bus.pipe_in_data  = bus.req_data[int'(winner)*DW +: DW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
        end
    end

    assign tag_in = '{valid: issue, id: winner};

    tag_delay_line #(
        .WIDTH (1 + IDW),
        .DEPTH (LATENCY)
    ) u_tag_line (
        .clk       (clk),
        .reset     (reset),
        .din       (tag_in),
        .dout      (tag_out),
        .any_valid (tag_busy)
    );

    assign retire        = tag_out.valid;
    assign bus.rsp_valid = retire ? (NUM_REQ'(1) << tag_out.id) : '0;
    assign bus.rsp_data  = bus.pipe_out_data;

    // Simultaneous issue and retire cancel, so the count is bounded by LATENCY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_flight_q <= '0;
        end else begin
            case ({issue, retire})
                2'b10:   in_flight_q <= in_flight_q + 1'b1;
                2'b01:   in_flight_q <= in_flight_q - 1'b1;
                default: in_flight_q <= in_flight_q;
            endcase
        end
    end

    assign bus.in_flight = in_flight_q;
    assign bus.idle      = (in_flight_q == '0) && !tag_busy && !issue;

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Scoreboard bench for pipe_share_arbiter: the bench plays the datapath and
// expects each issued operand's result back at its owner LATENCY cycles later.
module tb_pipe_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 16;
    localparam int RW      = 16;
    localparam int LATENCY = 5;
    localparam int CW      = $clog2(LATENCY + 1);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_share_arbiter_if #(
        .NUM_REQ (NUM_REQ), .DW (DW), .RW (RW), .LATENCY (LATENCY)
    ) bus ();

    pipe_share_arbiter #(
        .NUM_REQ (NUM_REQ), .DW (DW), .RW (RW), .LATENCY (LATENCY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int            when;
        int            id;
        logic [RW-1:0] res;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   rr_model = 0;

    logic [NUM_REQ-1:0] obs_gnt;
    logic [NUM_REQ-1:0] obs_rsp;
    logic [DW-1:0]      obs_pdata;
    logic [CW-1:0]      obs_inflight;
    logic               obs_idle;
    logic               obs_pvalid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Datapath stand-in: any fixed transform makes misrouted results visible.
    function automatic logic [RW-1:0] datapath(input logic [DW-1:0] d);
        return d ^ 16'h5a5a;
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int ptr);
        for (int off = 0; off < NUM_REQ; off++) begin
            if (r[(ptr + off) % NUM_REQ]) return (ptr + off) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic step(input logic en, input logic [NUM_REQ-1:0] r,
                        input logic [NUM_REQ*DW-1:0] d);
        logic [NUM_REQ-1:0] exp_rsp;
        logic [RW-1:0]      exp_data;
        logic               iss;
        int                 w;
        @(negedge clk);
        bus.issue_en      = en;
        bus.req           = r;
        bus.req_data      = d;
        bus.pipe_out_data = RW'($urandom);
        exp_rsp  = '0;
        exp_data = '0;
        if (sb.size() > 0 && sb[0].when == cyc) begin
            exp_rsp[sb[0].id] = 1'b1;
            exp_data          = sb[0].res;
            bus.pipe_out_data = exp_data;
        end
        iss = en && (r != '0);
        w   = iss ? rr_pick(r, rr_model) : 0;
        #1;
        obs_gnt      = bus.gnt;
        obs_rsp      = bus.rsp_valid;
        obs_pdata    = bus.pipe_in_data;
        obs_inflight = bus.in_flight;
        obs_idle     = bus.idle;
        obs_pvalid   = bus.pipe_in_valid;
        check("in_flight", 64'(bus.in_flight), 64'(sb.size()));
        check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp));
        if (exp_rsp != '0) check("rsp_data", 64'(bus.rsp_data), 64'(exp_data));
        check("idle", 64'(bus.idle), 64'(sb.size() == 0 && !iss));
        check("pipe_in_valid", 64'(bus.pipe_in_valid), 64'(iss));
        if (iss) begin
            check("gnt", 64'(bus.gnt), 64'(1) << w);
            check("pipe_in_data", 64'(bus.pipe_in_data), 64'(d[w*DW +: DW]));
        end else begin
            check("gnt_none", 64'(bus.gnt), 64'(0));
        end
        if (exp_rsp != '0) void'(sb.pop_front());
        if (iss) begin
            sb.push_back('{cyc + LATENCY, w, datapath(d[w*DW +: DW])});
            rr_model = (w + 1) % NUM_REQ;
        end
        cyc++;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.issue_en = 1'b1;
        bus.req      = '1;
        #1;
        check("rst_gnt", 64'(bus.gnt), 64'(0));
        check("rst_pipe_valid", 64'(bus.pipe_in_valid), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_in_flight", 64'(bus.in_flight), 64'(0));
        check("rst_idle", 64'(bus.idle), 64'(1));
        @(posedge clk);
        #1;
        check("rst_gnt_edge", 64'(bus.gnt), 64'(0));
        bus.req = '0;
        reset   = 1'b0;
        sb.delete();
        rr_model = 0;
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM_REQ*DW-1:0] tdata;
        tdata             = 64'h4444_3333_2222_1111;
        reset             = 1'b1;
        bus.issue_en      = 1'b0;
        bus.req           = '0;
        bus.req_data      = '0;
        bus.pipe_out_data = '0;
        pulse_reset();

        // Single request from requester 2.
        step(1'b1, 4'b0100, tdata);
        check("t1_gnt", 64'(obs_gnt), 64'(4'b0100));
        check("t1_pdata", 64'(obs_pdata), 64'(16'h3333));
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 4'b0000, tdata);
            check("t1_in_flight", 64'(obs_inflight), (i <= 5) ? 64'(1) : 64'(0));
            check("t1_rsp", 64'(obs_rsp), (i == 5) ? 64'(4'b0100) : 64'(0));
        end

        // All requesters from reset: rotating grants, results in the same order.
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'b1111, tdata);
            check("t2_gnt", 64'(obs_gnt), 64'(1) << (i % 4));
            check("t2_in_flight", 64'(obs_inflight), (i < 5) ? 64'(i) : 64'(5));
            if (i >= 5) check("t2_rsp", 64'(obs_rsp), 64'(1) << ((i - 5) % 4));
        end
        for (int j = 0; j < 5; j++) begin
            step(1'b1, 4'b0000, tdata);
            check("t2_drain_rsp", 64'(obs_rsp), 64'(1) << ((3 + j) % 4));
        end

        // Move pointer to 2, then req=1010 grants 3 before 1.
        step(1'b1, 4'b0010, tdata);
        step(1'b1, 4'b1010, tdata);
        check("t3_first", 64'(obs_gnt), 64'(4'b1000));
        step(1'b1, 4'b1010, tdata);
        check("t3_second", 64'(obs_gnt), 64'(4'b0010));
        step(1'b1, 4'b1111, tdata);
        check("t3_ptr_is_2", 64'(obs_gnt), 64'(4'b0100));

        // Drain mode holds off grants while earlier ops still retire.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b1111, tdata);
            check("t4_hold_gnt", 64'(obs_gnt), 64'(0));
            check("t4_hold_valid", 64'(obs_pvalid), 64'(0));
        end
        step(1'b1, 4'b1111, tdata);
        check("t4_resume", 64'(obs_gnt), 64'(4'b1000));
        for (int i = 0; i < 7; i++) step(1'b0, 4'b0000, tdata);
        check("t4_idle", 64'(obs_idle), 64'(1));
        check("t4_in_flight", 64'(obs_inflight), 64'(0));

        // Reset with three ops in flight: none of them may retire.
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, tdata);
        step(1'b1, 4'b0000, tdata);
        pulse_reset();
        step(1'b1, 4'b0000, tdata);
        check("t5_in_flight", 64'(obs_inflight), 64'(0));
        check("t5_idle", 64'(obs_idle), 64'(1));
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'b0000, tdata);
            check("t5_no_rsp", 64'(obs_rsp), 64'(0));
        end

        // Steady stream: issue and retire every cycle keeps the count at LATENCY.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 4'b1111, {$urandom, $urandom});
            if (i >= 5) check("t6_steady", 64'(obs_inflight), 64'(LATENCY));
        end

        // Random traffic against the scoreboard.
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 3) != 0, NUM_REQ'($urandom), {$urandom, $urandom});
        end
        for (int i = 0; i < 7; i++) step(1'b0, 4'b0000, tdata);
        check("final_idle", 64'(obs_idle), 64'(1));
        check("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
